// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot active-low column drive, synchronized
// row sampling, per-frame classification, press/release debounce and a
// valid/acknowledge output register with overrun flag.
module keypad_scanner #(
   parameter int unsigned T_SCAN   = 100000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   input  logic       key_ack,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_down,
   output logic       overrun
);

   localparam int unsigned SW = (T_SCAN > 1) ? $clog2(T_SCAN) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_DEB = 2'd1,
      HELD      = 2'd2,
      REL_DEB   = 2'd3
   } state_t;

   logic [3:0]    row_s1;
   logic [3:0]    row_s2;
   logic [SW-1:0] slot_cnt;
   logic [1:0]    col_idx;
   logic [1:0]    acc_cnt;
   logic [3:0]    acc_code;
   state_t        state;
   logic [3:0]    cand;
   logic [CW-1:0] deb_cnt;

   logic          slot_last_c;
   logic          frame_end_c;
   logic [2:0]    ones_c;
   logic [1:0]    hit_row_c;
   logic [2:0]    total_c;
   logic [3:0]    frame_code_c;
   logic          frame_empty_c;
   logic          frame_single_c;
   logic          cnt_last_c;
   logic          match_c;
   logic          press_evt_c;

   // Two-flop synchronizer for the asynchronous row lines (idle high).
   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= row;
         row_s2 <= row_s1;
      end
   end

   // Slot timing and column drive; COL steps on the edge after a slot's last cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt <= '0;
         col_idx  <= 2'd0;
         col      <= 4'b1110;
      end else if (slot_last_c) begin
         slot_cnt <= '0;
         col_idx  <= col_idx + 2'd1;
         col      <= {col[2:0], col[3]};
      end else begin
         slot_cnt <= slot_cnt + SW'(1);
      end
   end

   // Count low row bits in the current sample and locate the (single) one.
   always_comb begin
      ones_c    = 3'd0;
      hit_row_c = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!row_s2[i]) begin
            ones_c    = ones_c + 3'd1;
            hit_row_c = 2'(i);
         end
      end
   end

   // Frame classification including the slot being sampled this cycle.
   always_comb begin
      slot_last_c    = (slot_cnt == SW'(T_SCAN - 1));
      frame_end_c    = slot_last_c && (col_idx == 2'd3);
      total_c        = 3'(acc_cnt) + ones_c;
      frame_code_c   = (acc_cnt == 2'd1) ? acc_code : {hit_row_c, col_idx};
      frame_empty_c  = (total_c == 3'd0);
      frame_single_c = (total_c == 3'd1);
      cnt_last_c     = (deb_cnt == CW'(DEBOUNCE - 1));
      match_c        = frame_single_c && (frame_code_c == cand);
      press_evt_c    = frame_end_c && frame_single_c &&
                       (((state == IDLE) && (DEBOUNCE == 1)) ||
                        ((state == PRESS_DEB) && match_c && cnt_last_c));
   end

   // Accumulate low-bit count (saturating at 2) and the first hit code per frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt  <= 2'd0;
         acc_code <= 4'd0;
      end else if (frame_end_c) begin
         acc_cnt  <= 2'd0;
         acc_code <= 4'd0;
      end else if (slot_last_c) begin
         acc_cnt <= (total_c >= 3'd2) ? 2'd2 : total_c[1:0];
         if (total_c == 3'd1) begin
            acc_code <= frame_code_c;
         end
      end
   end

   // Debounce state machine, stepped once per frame end; drives key_down.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cand     <= 4'd0;
         deb_cnt  <= '0;
         key_down <= 1'b0;
      end else if (frame_end_c) begin
         case (state)
            IDLE: begin
               if (frame_single_c) begin
                  cand <= frame_code_c;
                  if (DEBOUNCE == 1) begin
                     state    <= HELD;
                     key_down <= 1'b1;
                  end else begin
                     state   <= PRESS_DEB;
                     deb_cnt <= CW'(1);
                  end
               end
            end
            PRESS_DEB: begin
               if (match_c) begin
                  if (cnt_last_c) begin
                     state    <= HELD;
                     key_down <= 1'b1;
                  end else begin
                     deb_cnt <= deb_cnt + CW'(1);
                  end
               end else if (frame_single_c) begin
                  cand    <= frame_code_c;
                  deb_cnt <= CW'(1);
               end else begin
                  state <= IDLE;
               end
            end
            HELD: begin
               if (frame_empty_c) begin
                  if (DEBOUNCE == 1) begin
                     state    <= IDLE;
                     key_down <= 1'b0;
                  end else begin
                     state   <= REL_DEB;
                     deb_cnt <= CW'(1);
                  end
               end
            end
            REL_DEB: begin
               if (frame_empty_c) begin
                  if (cnt_last_c) begin
                     state    <= IDLE;
                     key_down <= 1'b0;
                  end else begin
                     deb_cnt <= deb_cnt + CW'(1);
                  end
               end else begin
                  state <= HELD;
               end
            end
            default: begin
               state    <= IDLE;
               key_down <= 1'b0;
            end
         endcase
      end
   end

   // Output register handshake; an event during a pending code sets overrun
   // and wins over the ack clearing overrun on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         overrun   <= 1'b0;
      end else begin
         if (key_valid && key_ack) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
         end
         if (press_evt_c) begin
            if (key_valid) begin
               overrun <= 1'b1;
            end else begin
               key_valid <= 1'b1;
               key_code  <= frame_code_c;
            end
         end
      end
   end

endmodule
